// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: prefix codes, frame geometry, event layout and frame FSM states.
// Pure declarations, no logic or latency of its own.
// No backpressure involved; imported by the frame receiver and the keyboard top.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam int         PS2_FRAME_LEN = 11;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_ev_t;

    typedef enum logic [1:0] {
        FR_IDLE,
        FR_RX,
        FR_CHECK
    } frame_state_t;

    // Odd parity over data bits plus parity bit (frame bits 1..9).
    function automatic logic frame_parity_ok(input logic [PS2_FRAME_LEN-1:0] f);
        return ^f[9:1];
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: synchronisers, glitch filter, frame FSM with timeout, byte strobe.
// Strobe is asserted in the CHECK cycle, one clock after the falling edge of the stop bit.
// No backpressure: bytes and error pulses are single-cycle and must be consumed on sight.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       ps2c_i,
    input  logic       ps2d_i,
    output logic       byte_vld_o,
    output logic [7:0] byte_o,
    output logic       par_err_o,
    output logic       frm_err_o
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic                     c_s1_q, c_s2_q, d_s1_q, d_s2_q;
    logic                     filt_q, filt_d, prev_q;
    logic [FW-1:0]            fcnt_q, fcnt_d;
    logic                     fall;
    frame_state_t             state_q, state_d;
    logic [PS2_FRAME_LEN-1:0] sh_q, sh_d;
    logic [3:0]               bcnt_q, bcnt_d;
    logic [TW-1:0]            tmo_q, tmo_d;

    // Filter counts consecutive samples that disagree with the current filtered level.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (c_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = c_s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign fall   = prev_q & ~filt_q;
    assign byte_o = sh_q[8:1];

    always_comb begin
        state_d    = state_q;
        sh_d       = sh_q;
        bcnt_d     = bcnt_q;
        tmo_d      = tmo_q;
        byte_vld_o = 1'b0;
        par_err_o  = 1'b0;
        frm_err_o  = 1'b0;
        unique case (state_q)
            FR_IDLE: begin
                tmo_d = '0;
                if (fall) begin
                    sh_d    = {d_s2_q, sh_q[PS2_FRAME_LEN-1:1]};
                    bcnt_d  = 4'd1;
                    state_d = FR_RX;
                end
            end
            FR_RX: begin
                if (fall) begin
                    sh_d  = {d_s2_q, sh_q[PS2_FRAME_LEN-1:1]};
                    tmo_d = '0;
                    if (bcnt_q == 4'(PS2_FRAME_LEN - 1)) begin
                        state_d = FR_CHECK;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d   = FR_IDLE;
                    frm_err_o = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            FR_CHECK: begin
                state_d    = FR_IDLE;
                par_err_o  = ~frame_parity_ok(sh_q);
                frm_err_o  = sh_q[0] | ~sh_q[PS2_FRAME_LEN-1];
                byte_vld_o = ~par_err_o & ~frm_err_o;
            end
            default: state_d = FR_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            c_s1_q  <= 1'b1;
            c_s2_q  <= 1'b1;
            d_s1_q  <= 1'b1;
            d_s2_q  <= 1'b1;
            filt_q  <= 1'b1;
            prev_q  <= 1'b1;
            fcnt_q  <= '0;
            state_q <= FR_IDLE;
            sh_q    <= '0;
            bcnt_q  <= '0;
            tmo_q   <= '0;
        end else begin
            c_s1_q  <= ps2c_i;
            c_s2_q  <= c_s1_q;
            d_s1_q  <= ps2d_i;
            d_s2_q  <= d_s1_q;
            filt_q  <= filt_d;
            prev_q  <= filt_q;
            fcnt_q  <= fcnt_d;
            state_q <= state_d;
            sh_q    <= sh_d;
            bcnt_q  <= bcnt_d;
            tmo_q   <= tmo_d;
        end
    end

endmodule

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: E0/F0 prefix decoder, event FIFO and sticky error flags.
// Byte strobe to ev_valid is 2 clocks; head outputs are registered.
// Valid/ready output; when the FIFO is full and not popping, new events are dropped and err_ovf set.
module ps2_kbd_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int FIFO_DEPTH  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        ps2c,
    input  logic                        ps2d,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [7:0]                  ev_code,
    output logic                        ev_break,
    output logic                        ev_ext,
    output logic [$clog2(FIFO_DEPTH):0] ev_count,
    output logic                        err_parity,
    output logic                        err_frame,
    output logic                        err_ovf,
    input  logic                        clr_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic       rx_vld, rx_par_err, rx_frm_err;
    logic [7:0] rx_byte;

    ps2_frame_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .ps2c_i    (ps2c),
        .ps2d_i    (ps2d),
        .byte_vld_o(rx_vld),
        .byte_o    (rx_byte),
        .par_err_o (rx_par_err),
        .frm_err_o (rx_frm_err)
    );

    logic    ext_q, ext_d, brk_q, brk_d, push_q, push_d;
    ps2_ev_t push_ev_q, push_ev_d;

    always_comb begin
        ext_d     = ext_q;
        brk_d     = brk_q;
        push_d    = 1'b0;
        push_ev_d = push_ev_q;
        if (rx_vld) begin
            if (rx_byte == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_byte == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                push_d    = 1'b1;
                push_ev_d = '{ext: ext_q, brk: brk_q, code: rx_byte};
                ext_d     = 1'b0;
                brk_d     = 1'b0;
            end
        end
    end

    ps2_ev_t       mem_q [FIFO_DEPTH];
    ps2_ev_t       head_q, head_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          full, do_pop, do_push, ovf_set;

    assign ev_valid = (cnt_q != '0);
    assign full     = (cnt_q == CW'(FIFO_DEPTH));
    assign do_pop   = ev_valid & ev_ready;
    assign do_push  = push_q & (~full | do_pop);
    assign ovf_set  = push_q & full & ~do_pop;
    assign rd_nxt   = rd_ptr_q + 1'b1;

    // Head register tracks what mem[rd_ptr] will hold after this cycle's push/pop.
    always_comb begin
        cnt_d  = cnt_q + CW'(do_push) - CW'(do_pop);
        head_d = head_q;
        if (do_push && (cnt_q == '0 || (cnt_q == CW'(1) && do_pop))) begin
            head_d = push_ev_q;
        end else if (do_pop && cnt_q > CW'(1)) begin
            head_d = mem_q[rd_nxt];
        end
    end

    assign ev_code  = head_q.code;
    assign ev_break = head_q.brk;
    assign ev_ext   = head_q.ext;
    assign ev_count = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_ev_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            push_q     <= 1'b0;
            push_ev_q  <= '0;
            head_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            err_parity <= 1'b0;
            err_frame  <= 1'b0;
            err_ovf    <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            push_q     <= push_d;
            push_ev_q  <= push_ev_d;
            head_q     <= head_d;
            cnt_q      <= cnt_d;
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_nxt;
            // A new error in the same cycle as clr_err survives the clear.
            err_parity <= (err_parity & ~clr_err) | rx_par_err;
            err_frame  <= (err_frame & ~clr_err) | rx_frm_err;
            err_ovf    <= (err_ovf & ~clr_err) | ovf_set;
        end
    end

endmodule
